// File: rtl/if_else_seq_pkg.sv
// if_else_seq_pkg
//   Shared definitions for the if/else segment sequencer:
//   - default WIDTH / N_ITER / DP_LAT values
//   - controller state encoding
//   - index/counter width helper (clog2 with a floor of 1 bit)
package if_else_seq_pkg;

    localparam int unsigned DEF_WIDTH  = 32;
    localparam int unsigned DEF_N_ITER = 16;
    localparam int unsigned DEF_DP_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } seq_state_t;

    // Width needed to hold 0..n-1, never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/if_else_seq_timer.sv
// if_else_seq_timer
//   Datapath latency timer. Loaded with DP_LAT-1 when an operand set is
//   accepted, then counts down once per enabled cycle. expire is high while
//   the count is zero, which marks the cycle in which the datapath result
//   is valid.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous active-high reset (count -> 0)
//     load   in   reload the count with DP_LAT-1
//     step   in   decrement (saturates at zero)
//     expire out  count has reached zero
module if_else_seq_timer
    import if_else_seq_pkg::*;
#(
    parameter int unsigned DP_LAT = DEF_DP_LAT
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic step,
    output logic expire
);

    localparam int unsigned CW = idx_width(DP_LAT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(DP_LAT - 1);
        end else if (step && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/if_else_seq_ctrl.sv
// if_else_seq_ctrl
//   Sequencer for one unrolled if/else segment datapath. Accepts N_ITER
//   operand sets over a valid/ready stream, presents each one on dp_* and
//   holds it for DP_LAT cycles, captures dp_result and emits it downstream
//   with its element index and a last flag.
//   Ports:
//     clk, reset           clock, synchronous active-high reset
//     start, abort         begin burst (IDLE only) / cancel burst
//     busy, done           not-idle status / one-cycle completion pulse
//     in_valid, in_ready   operand stream handshake
//     in_bit, in_ref, in_ref_m   condition word, if- and else-references
//     dp_input_bit, dp_ref, dp_ref_m   registered operands to datapath
//     dp_result            datapath combined result
//     out_valid, out_ready result stream handshake
//     out_data, out_idx, out_last      result, element index, final flag
module if_else_seq_ctrl
    import if_else_seq_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned N_ITER = DEF_N_ITER,
    parameter int unsigned DP_LAT = DEF_DP_LAT,
    parameter int unsigned IDXW   = idx_width(N_ITER)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_bit,
    input  logic [WIDTH-1:0] in_ref,
    input  logic [WIDTH-1:0] in_ref_m,
    output logic [WIDTH-1:0] dp_input_bit,
    output logic [WIDTH-1:0] dp_ref,
    output logic [WIDTH-1:0] dp_ref_m,
    input  logic [WIDTH-1:0] dp_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [IDXW-1:0]  out_idx,
    output logic             out_last
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N_ITER - 1);

    seq_state_t      state, state_next;
    logic [IDXW-1:0] idx;

    logic burst_go;   // IDLE -> FETCH, clear index
    logic load_dp;    // operand handshake
    logic capture;    // latch datapath result
    logic pop;        // result handshake
    logic advance;    // move to next element
    logic lat_step;
    logic lat_expire;

    if_else_seq_timer #(
        .DP_LAT(DP_LAT)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (load_dp),
        .step  (lat_step),
        .expire(lat_expire)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Abort overrides everything: it forces IDLE and suppresses every strobe,
    // so in_ready and done are also masked in the abort cycle.
    always_comb begin
        state_next = state;
        busy       = (state != ST_IDLE);
        done       = 1'b0;
        in_ready   = 1'b0;
        burst_go   = 1'b0;
        load_dp    = 1'b0;
        capture    = 1'b0;
        pop        = 1'b0;
        advance    = 1'b0;
        lat_step   = 1'b0;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        burst_go   = 1'b1;
                        state_next = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        load_dp    = 1'b1;
                        state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    lat_step = 1'b1;
                    if (lat_expire) begin
                        capture    = 1'b1;
                        state_next = ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        pop = 1'b1;
                        if (out_last) begin
                            state_next = ST_DONE;
                        end else begin
                            advance    = 1'b1;
                            state_next = ST_FETCH;
                        end
                    end
                end
                ST_DONE: begin
                    done       = 1'b1;
                    state_next = ST_IDLE;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx          <= '0;
            dp_input_bit <= '0;
            dp_ref       <= '0;
            dp_ref_m     <= '0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_idx      <= '0;
            out_last     <= 1'b0;
        end else begin
            if (burst_go) begin
                idx <= '0;
            end else if (advance && (idx != LAST_IDX)) begin
                idx <= idx + 1'b1;
            end
            if (load_dp) begin
                dp_input_bit <= in_bit;
                dp_ref       <= in_ref;
                dp_ref_m     <= in_ref_m;
            end
            if (capture) begin
                out_data  <= dp_result;
                out_valid <= 1'b1;
                out_idx   <= idx;
                out_last  <= (idx == LAST_IDX);
            end
            if (pop || abort) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_else_seq_ctrl.sv
// tb_if_else_seq_ctrl
//   Directed bench for if_else_seq_ctrl with N_ITER=4, DP_LAT=2. The
//   datapath is modelled as a one-register mux (bit0 of the condition word
//   selects ref or ref_m), so its output is valid exactly DP_LAT edges after
//   the operands are accepted.
module tb_if_else_seq_ctrl;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned N_ITER = 4;
    localparam int unsigned DP_LAT = 2;
    localparam int unsigned IDXW   = 2;

    logic             clk = 1'b0;
    logic             reset, start, abort;
    logic             busy, done;
    logic             in_valid, in_ready;
    logic [WIDTH-1:0] in_bit, in_ref, in_ref_m;
    logic [WIDTH-1:0] dp_input_bit, dp_ref, dp_ref_m, dp_result;
    logic             out_valid, out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_idx;
    logic             out_last;
    logic [WIDTH-1:0] dp_pipe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) dp_pipe <= dp_input_bit[0] ? dp_ref : dp_ref_m;
    assign dp_result = dp_pipe;

    if_else_seq_ctrl #(
        .WIDTH (WIDTH),
        .N_ITER(N_ITER),
        .DP_LAT(DP_LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bit      (in_bit),
        .in_ref      (in_ref),
        .in_ref_m    (in_ref_m),
        .dp_input_bit(dp_input_bit),
        .dp_ref      (dp_ref),
        .dp_ref_m    (dp_ref_m),
        .dp_result   (dp_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k);
        in_bit   = (k % 2 == 0) ? 32'd1 : 32'd0;
        in_ref   = 32'hA0 + 32'(k);
        in_ref_m = 32'hB0 + 32'(k);
    endtask

    task automatic check_reset_vals(input string pfx);
        check({pfx, "_busy"},      32'(busy),      0);
        check({pfx, "_done"},      32'(done),      0);
        check({pfx, "_in_ready"},  32'(in_ready),  0);
        check({pfx, "_out_valid"}, 32'(out_valid), 0);
        check({pfx, "_out_last"},  32'(out_last),  0);
        check({pfx, "_out_idx"},   32'(out_idx),   0);
        check({pfx, "_out_data"},  out_data,       0);
        check({pfx, "_dp_bit"},    dp_input_bit,   0);
        check({pfx, "_dp_ref"},    dp_ref,         0);
        check({pfx, "_dp_ref_m"},  dp_ref_m,       0);
    endtask

    // Full burst. Optionally stalls out_ready for 5 cycles on element
    // stall_idx and withholds in_valid for 3 cycles on element gap_idx.
    // Cycle 1 is the cycle in which start is high.
    task automatic run_burst(input string pfx, input int stall_idx, input int gap_idx,
                             input int exp_done_cyc);
        int i = 0;
        int cyc = 1;
        int nrec = 0;
        int done_cyc = -1;
        int done_cnt = 0;
        int stall_cnt = 0;
        int gap_cnt = 0;
        logic [31:0] rdata [4];
        logic [31:0] ridx  [4];
        logic [31:0] rlast [4];
        bit acc;
        set_ops(0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        for (int unsigned t = 0; t < 80; t++) begin
            out_ready = 1'b1;
            if (out_valid && int'(out_idx) == stall_idx && stall_cnt < 5) begin
                out_ready = 1'b0;
                stall_cnt++;
                check($sformatf("%s_stall_data%0d", pfx, stall_cnt), out_data, 32'hB1);
                check($sformatf("%s_stall_idx%0d", pfx, stall_cnt), 32'(out_idx), 1);
                check($sformatf("%s_stall_rdy%0d", pfx, stall_cnt), 32'(in_ready), 0);
            end
            in_valid = 1'b1;
            if (in_ready && i == gap_idx && gap_cnt < 3) begin
                in_valid = 1'b0;
                gap_cnt++;
                check($sformatf("%s_gap_ref%0d", pfx, gap_cnt), dp_ref, 32'hA1);
                check($sformatf("%s_gap_refm%0d", pfx, gap_cnt), dp_ref_m, 32'hB1);
                check($sformatf("%s_gap_fetch%0d", pfx, gap_cnt), 32'(in_ready), 1);
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (out_valid && out_ready && nrec < 4) begin
                rdata[nrec] = out_data;
                ridx[nrec]  = 32'(out_idx);
                rlast[nrec] = 32'(out_last);
                nrec++;
            end
            acc = in_valid && in_ready;
            tick();
            cyc++;
            start = 1'b0;
            if (acc) begin
                i++;
                set_ops(i);
            end
            if (done_cyc >= 0 && cyc > done_cyc + 3) break;
        end
        in_valid = 1'b0;
        check({pfx, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
        check({pfx, "_done_cnt"}, 32'(done_cnt), 1);
        check({pfx, "_nrec"}, 32'(nrec), 4);
        for (int k = 0; k < nrec; k++) begin
            check($sformatf("%s_data%0d", pfx, k), rdata[k],
                  (k % 2 == 0) ? 32'hA0 + 32'(k) : 32'hB0 + 32'(k));
            check($sformatf("%s_idx%0d", pfx, k), ridx[k], 32'(k));
            check($sformatf("%s_last%0d", pfx, k), rlast[k], (k == 3) ? 32'd1 : 32'd0);
        end
        check({pfx, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        bit hit;
        bit acc;
        int i;
        reset = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_ops(0);
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("rst");

        // Plain burst, streams tied high.
        run_burst("norm", -1, -1, 18);

        // Output stall on idx 1, input gap on idx 2.
        run_burst("stall", 1, 2, 26);

        // Abort in WAIT of element 2.
        set_ops(0);
        in_valid = 1'b1;
        out_ready = 1'b1;
        start = 1'b1;
        i = 0;
        hit = 1'b0;
        for (int unsigned t = 0; t < 40; t++) begin
            acc = in_valid && in_ready;
            tick();
            start = 1'b0;
            if (acc) begin
                if (i == 2) begin
                    hit = 1'b1;
                    break;
                end
                i++;
                set_ops(i);
            end
        end
        check("abort_reach", 32'(hit), 1);
        check("abort_in_wait_busy", 32'(busy), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_out_valid", 32'(out_valid), 0);
        check("abort_in_ready", 32'(in_ready), 0);
        check("abort_done", 32'(done), 0);
        check("abort_dp_ref", dp_ref, 32'hA2);
        for (int unsigned t = 0; t < 3; t++) begin
            tick();
            check($sformatf("abort_nodone%0d", t), 32'(done), 0);
            check($sformatf("abort_idle%0d", t), 32'(busy), 0);
        end
        run_burst("after_abort", -1, -1, 18);

        // Reset while holding in EMIT.
        set_ops(0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        start = 1'b1;
        hit = 1'b0;
        for (int unsigned t = 0; t < 20; t++) begin
            tick();
            start = 1'b0;
            if (out_valid) begin
                hit = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        check("emit_reach", 32'(hit), 1);
        check("emit_data", out_data, 32'hA0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("rst_emit");

        // start and abort together: abort wins.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", 32'(busy), 0);
        check("sa_in_ready", 32'(in_ready), 0);
        tick();
        check_reset_vals("sa");
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_else_seq_ctrl.md
# if_else_seq_ctrl

Sequencer for one unrolled if/else segment datapath (condition unit plus if/else branch units plus result mux). Accepts a burst of N_ITER operand sets (condition word, if-branch reference, else-branch reference) over a valid/ready stream. Drives each set to the datapath and holds it stable for the datapath's fixed latency, then captures the combined result and emits it downstream with an index and last flag. Sits between the array-fetch logic and the result writeback in the unrolled modulation pipeline.

## Interface
- WIDTH, 32, data width of condition word, references and result
- N_ITER, 16, elements per burst (≥1)
- DP_LAT, 2, cycles from operands stable to datapath result valid (≥1)
- IDXW, $clog2(N_ITER) (min 1), index width
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin a burst; sampled only in IDLE
- abort  in  1  synchronous burst cancel
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at burst completion
- in_valid  in  1  operand set available
- in_ready  out  1  controller accepts operand set
- in_bit  in  WIDTH  condition word
- in_ref  in  WIDTH  if-branch reference
- in_ref_m  in  WIDTH  else-branch reference
- dp_input_bit  out  WIDTH  registered condition word to datapath
- dp_ref  out  WIDTH  registered if-branch reference to datapath
- dp_ref_m  out  WIDTH  registered else-branch reference to datapath
- dp_result  in  WIDTH  combined segment result from datapath
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  WIDTH  captured result
- out_idx  out  IDXW  element index of out_data, 0..N_ITER-1
- out_last  out  1  high with out_valid on final element

## Operation
- States: IDLE, FETCH, WAIT, EMIT, DONE.
- IDLE: start=1 and abort=0 -> FETCH, idx<=0. Otherwise stay.
- FETCH: in_ready=1. On in_valid: load dp_* registers from in_*, lat_cnt<=0 -> WAIT.
- WAIT: dp_* held constant. lat_cnt increments each cycle. At lat_cnt==DP_LAT-1: out_data<=dp_result, out_valid<=1, out_idx<=idx, out_last<=(idx==N_ITER-1) -> EMIT.
- EMIT: out_valid, out_data, out_idx, out_last held until out_ready. On handshake: out_valid<=0. If out_last -> DONE, else idx<=idx+1 -> FETCH.
- DONE: done=1 for one cycle -> IDLE.
- abort=1 in any state: next state IDLE, out_valid<=0, in_ready=0, no done pulse. dp_* retain last value. abort beats start in the same cycle.
- in_ready is combinational from state only (no dependence on in_valid). in_ready=0 outside FETCH.
- idx never exceeds N_ITER-1; no wrap within a burst.
- dp_result is ignored outside the capture cycle.

## Timing
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, out_last=0, out_idx=0, out_data=0, dp_*=0. State IDLE, idx=0, lat_cnt=0.
- start at edge E -> FETCH at E+1 (busy=1, in_ready=1).
- Operand accept at edge A -> dp_* valid from A. Result sampled at edge A+DP_LAT. out_valid high from A+DP_LAT.
- Output handshake at edge H -> in_ready high in the cycle after H, or done high in the cycle after H if last.
- Per-element period with in_valid and out_ready tied high is DP_LAT+2 cycles. Full burst from start to done is 1 + N_ITER·(DP_LAT+2) + 1 cycles.
- Reset mid-burst has the same effect as abort, with all registers also restored to their reset values.

## Structure
- Shared package if_else_seq_pkg:
  - state enum (IDLE, FETCH, WAIT, EMIT, DONE)
  - default WIDTH/N_ITER/DP_LAT localparams
  - the IDXW calculation
- One sub-module: if_else_seq_timer, the DP_LAT down-counter with load and expire.
- The if/else datapath is instantiated outside this block. Only the dp_* ports connect to it.

## Test plan
- N_ITER=4, DP_LAT=2, dp_result modelled as (bit0 of dp_input_bit ? dp_ref : dp_ref_m) after 2 cycles. in_bit=1,0,1,0, in_ref=0xA0+i, in_ref_m=0xB0+i -> out_data=0xA0,0xB1,0xA2,0xB3; out_idx=0..3; out_last only on idx 3; done once at cycle 18.
- Stall out_ready low for 5 cycles on idx 1 -> out_data/out_idx stable throughout, in_ready stays 0, no operand consumed.
- in_valid low for 3 cycles in FETCH -> dp_* unchanged, state stays FETCH, then normal accept.
- abort asserted during WAIT of idx 2 -> IDLE next cycle, out_valid=0, no done; subsequent start produces idx 0 first.
- reset asserted in EMIT, and start+abort together in IDLE -> all outputs at reset values; no burst begins.
